// File: rtl/memory_access_cycle_if.sv
// M->W bus bundle for memory_access_cycle (slave = MEM stage, master = driver/observer).
// Optional MEM_STATS_EN adds the LoadCount/StoreCount/TrapCount outputs.
interface memory_access_cycle_if;
    logic        ValidM;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;

    logic        ValidW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic        MisalignW;
`ifdef MEM_STATS_EN
    logic [31:0] LoadCount;
    logic [31:0] StoreCount;
    logic [31:0] TrapCount;
`endif

    modport slave (
        input  ValidM, RegWriteM, MemWriteM, ResultSrcM, funct3M, RD_M,
               ALUResultM, WriteDataM, PCPlus4M,
        output ValidW, RegWriteW, ResultSrcW, RD_W, ALUResultW, ReadDataW,
               PCPlus4W, MisalignW
`ifdef MEM_STATS_EN
        , output LoadCount, StoreCount, TrapCount
`endif
    );

    modport master (
        output ValidM, RegWriteM, MemWriteM, ResultSrcM, funct3M, RD_M,
               ALUResultM, WriteDataM, PCPlus4M,
        input  ValidW, RegWriteW, ResultSrcW, RD_W, ALUResultW, ReadDataW,
               PCPlus4W, MisalignW
`ifdef MEM_STATS_EN
        , input LoadCount, StoreCount, TrapCount
`endif
    );
endinterface

// File: rtl/memory_access_cycle.sv
// RV32 MEM stage: byte-enabled data memory, load extension, trap detection, M->W register.
// Optional MEM_STATS_EN adds load/store/trap counters.
module memory_access_cycle #(
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic           clk,
    input  logic           rst,
    memory_access_cycle_if.slave bus
);
    localparam int unsigned AW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          is_store, is_load, illegal, misalign, trap, do_write, do_load;
    logic [3:0]    be;
    logic [31:0]   wdata;

    // A store wins when MemWriteM and a load encoding are both set.
    always_comb begin
        idx      = bus.ALUResultM[AW+1:2];
        lane     = bus.ALUResultM[1:0];
        is_store = bus.MemWriteM;
        is_load  = (bus.ResultSrcM == 2'b01) && !bus.MemWriteM;
        illegal  = 1'b0;
        misalign = 1'b0;
        be       = '0;
        wdata    = '0;
        case (bus.funct3M)
            F3_B: begin
                be    = 4'b0001 << lane;
                wdata = {4{bus.WriteDataM[7:0]}};
            end
            F3_H: begin
                misalign = lane[0];
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{bus.WriteDataM[15:0]}};
            end
            F3_W: begin
                misalign = |lane;
                be       = '1;
                wdata    = bus.WriteDataM;
            end
            F3_BU:   illegal = is_store;
            F3_HU: begin
                illegal  = is_store;
                misalign = lane[0];
            end
            default: illegal = 1'b1;
        endcase
        trap     = bus.ValidM && (is_store || is_load) && (illegal || misalign);
        do_write = bus.ValidM && is_store && !trap && !rst;
        do_load  = bus.ValidM && is_load && !trap;
    end

    logic        valid_d, valid_q;
    logic        regwrite_d, regwrite_q;
    logic [1:0]  resultsrc_d, resultsrc_q;
    logic [4:0]  rd_d, rd_q;
    logic [31:0] alu_d, alu_q;
    logic [31:0] pc4_d, pc4_q;
    logic        misalign_d, misalign_q;
    logic        load_d, load_q;
    logic [1:0]  lane_d, lane_q;
    logic [2:0]  f3_d, f3_q;
    logic [31:0] raw_d, raw_q;

    logic [31:0] mem [MEM_DEPTH];

    always_comb begin
        valid_d     = bus.ValidM;
        regwrite_d  = bus.ValidM && bus.RegWriteM && !trap;
        resultsrc_d = bus.ResultSrcM;
        rd_d        = bus.RD_M;
        alu_d       = bus.ALUResultM;
        pc4_d       = bus.PCPlus4M;
        misalign_d  = trap;
        load_d      = do_load;
        lane_d      = lane;
        f3_d        = bus.funct3M;
        raw_d       = mem[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            regwrite_q  <= '0;
            resultsrc_q <= '0;
            rd_q        <= '0;
            alu_q       <= '0;
            pc4_q       <= '0;
            misalign_q  <= '0;
            load_q      <= '0;
            lane_q      <= '0;
            f3_q        <= '0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            rd_q        <= rd_d;
            alu_q       <= alu_d;
            pc4_q       <= pc4_d;
            misalign_q  <= misalign_d;
            load_q      <= load_d;
            lane_q      <= lane_d;
            f3_q        <= f3_d;
        end
    end

    // Raw read word is unreset so the array maps onto block RAM; load_q masks it instead.
    always_ff @(posedge clk) begin
        raw_q <= raw_d;
        if (do_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] rdata;

    always_comb begin
        rbyte = raw_q[8*lane_q +: 8];
        rhalf = lane_q[1] ? raw_q[31:16] : raw_q[15:0];
        rdata = '0;
        if (load_q) begin
            case (f3_q)
                F3_B:    rdata = {{24{rbyte[7]}}, rbyte};
                F3_H:    rdata = {{16{rhalf[15]}}, rhalf};
                F3_W:    rdata = raw_q;
                F3_BU:   rdata = {24'b0, rbyte};
                F3_HU:   rdata = {16'b0, rhalf};
                default: rdata = '0;
            endcase
        end
    end

    assign bus.ValidW     = valid_q;
    assign bus.RegWriteW  = regwrite_q;
    assign bus.ResultSrcW = resultsrc_q;
    assign bus.RD_W       = rd_q;
    assign bus.ALUResultW = alu_q;
    assign bus.ReadDataW  = rdata;
    assign bus.PCPlus4W   = pc4_q;
    assign bus.MisalignW  = misalign_q;

`ifdef MEM_STATS_EN
    logic [31:0] load_cnt_d, load_cnt_q;
    logic [31:0] store_cnt_d, store_cnt_q;
    logic [31:0] trap_cnt_d, trap_cnt_q;

    always_comb begin
        load_cnt_d  = load_cnt_q + {31'b0, do_load};
        store_cnt_d = store_cnt_q + {31'b0, do_write};
        trap_cnt_d  = trap_cnt_q + {31'b0, trap};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            trap_cnt_q  <= '0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
            trap_cnt_q  <= trap_cnt_d;
        end
    end

    assign bus.LoadCount  = load_cnt_q;
    assign bus.StoreCount = store_cnt_q;
    assign bus.TrapCount  = trap_cnt_q;
`endif
endmodule

// File: tb/tb_memory_access_cycle.sv
// Directed, table-driven bench for memory_access_cycle (counter checks under MEM_STATS_EN).
module tb_memory_access_cycle;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memory_access_cycle_if bus();

    memory_access_cycle #(.MEM_DEPTH(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [1:0] RS_ALU = 2'b00, RS_LD = 2'b01, RS_PC = 2'b10;
    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    typedef struct {
        string       nm;
        logic        v, rw, mw;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [31:0] addr, wd;
        logic        ev, erw, emis;
        logic [31:0] erd;
    } vec_t;

    vec_t tv[$];
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    function automatic vec_t mk(input string nm, input logic v, rw, mw, input logic [1:0] rs,
                                input logic [2:0] f3, input logic [31:0] addr, wd,
                                input logic ev, erw, emis, input logic [31:0] erd);
        vec_t t;
        t.nm = nm; t.v = v; t.rw = rw; t.mw = mw; t.rs = rs; t.f3 = f3;
        t.addr = addr; t.wd = wd; t.ev = ev; t.erw = erw; t.emis = emis; t.erd = erd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, rw, mw, input logic [1:0] rs, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] addr, wd, pc4);
        bus.ValidM     = v;
        bus.RegWriteM  = rw;
        bus.MemWriteM  = mw;
        bus.ResultSrcM = rs;
        bus.funct3M    = f3;
        bus.RD_M       = rd;
        bus.ALUResultM = addr;
        bus.WriteDataM = wd;
        bus.PCPlus4M   = pc4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ValidW"},     {31'b0, bus.ValidW},     32'h0);
        chk({tag, ".RegWriteW"},  {31'b0, bus.RegWriteW},  32'h0);
        chk({tag, ".ResultSrcW"}, {30'b0, bus.ResultSrcW}, 32'h0);
        chk({tag, ".RD_W"},       {27'b0, bus.RD_W},       32'h0);
        chk({tag, ".ALUResultW"}, bus.ALUResultW,          32'h0);
        chk({tag, ".ReadDataW"},  bus.ReadDataW,           32'h0);
        chk({tag, ".PCPlus4W"},   bus.PCPlus4W,            32'h0);
        chk({tag, ".MisalignW"},  {31'b0, bus.MisalignW},  32'h0);
`ifdef MEM_STATS_EN
        chk({tag, ".LoadCount"},  bus.LoadCount,  32'h0);
        chk({tag, ".StoreCount"}, bus.StoreCount, 32'h0);
        chk({tag, ".TrapCount"},  bus.TrapCount,  32'h0);
`endif
    endtask

    initial begin
        int unsigned exp_ld, exp_st, exp_tr;
        vec_t t;

        tv.push_back(mk("sw10",      1,0,1,RS_ALU,W, 32'h10,       32'hDEADBEEF, 1,0,0,32'h0));
        tv.push_back(mk("lw10",      1,1,0,RS_LD, W, 32'h10,       32'h0,        1,1,0,32'hDEADBEEF));
        tv.push_back(mk("sw20",      1,0,1,RS_ALU,W, 32'h20,       32'h11223344, 1,0,0,32'h0));
        tv.push_back(mk("sb21",      1,0,1,RS_ALU,B, 32'h21,       32'hAAAAAA80, 1,0,0,32'h0));
        tv.push_back(mk("lb21",      1,1,0,RS_LD, B, 32'h21,       32'h0,        1,1,0,32'hFFFFFF80));
        tv.push_back(mk("lbu21",     1,1,0,RS_LD, BU,32'h21,       32'h0,        1,1,0,32'h00000080));
        tv.push_back(mk("lw20",      1,1,0,RS_LD, W, 32'h20,       32'h0,        1,1,0,32'h11228044));
        tv.push_back(mk("sw30",      1,0,1,RS_ALU,W, 32'h30,       32'h0,        1,0,0,32'h0));
        tv.push_back(mk("sh32",      1,0,1,RS_ALU,H, 32'h32,       32'h55558001, 1,0,0,32'h0));
        tv.push_back(mk("lh32",      1,1,0,RS_LD, H, 32'h32,       32'h0,        1,1,0,32'hFFFF8001));
        tv.push_back(mk("lhu32",     1,1,0,RS_LD, HU,32'h32,       32'h0,        1,1,0,32'h00008001));
        tv.push_back(mk("lw30",      1,1,0,RS_LD, W, 32'h30,       32'h0,        1,1,0,32'h80010000));
        tv.push_back(mk("sw40",      1,0,1,RS_ALU,W, 32'h40,       32'hCAFEF00D, 1,0,0,32'h0));
        tv.push_back(mk("lw13_trap", 1,1,0,RS_LD, W, 32'h13,       32'h0,        1,0,1,32'h0));
        tv.push_back(mk("sw42_trap", 1,0,1,RS_ALU,W, 32'h42,       32'h12345678, 1,0,1,32'h0));
        tv.push_back(mk("lw40",      1,1,0,RS_LD, W, 32'h40,       32'h0,        1,1,0,32'hCAFEF00D));
        tv.push_back(mk("lh21_trap", 1,1,0,RS_LD, H, 32'h21,       32'h0,        1,0,1,32'h0));
        tv.push_back(mk("ld011_trap",1,1,0,RS_LD, 3'b011,32'h40,   32'h0,        1,0,1,32'h0));
        tv.push_back(mk("st100_trap",1,0,1,RS_ALU,BU,32'h40,       32'hFFFFFFFF, 1,0,1,32'h0));
        tv.push_back(mk("lb43",      1,1,0,RS_LD, B, 32'h43,       32'h0,        1,1,0,32'hFFFFFFCA));
        tv.push_back(mk("lbu40",     1,1,0,RS_LD, BU,32'h40,       32'h0,        1,1,0,32'h0000000D));
        tv.push_back(mk("lhu42",     1,1,0,RS_LD, HU,32'h42,       32'h0,        1,1,0,32'h0000CAFE));
        tv.push_back(mk("sw50",      1,0,1,RS_ALU,W, 32'h50,       32'h12345678, 1,0,0,32'h0));
        tv.push_back(mk("bub_sw50",  0,1,1,RS_ALU,W, 32'h50,       32'h99999999, 0,0,0,32'h0));
        tv.push_back(mk("bub_lw13",  0,1,0,RS_LD, W, 32'h13,       32'h0,        0,0,0,32'h0));
        tv.push_back(mk("lw50",      1,1,0,RS_LD, W, 32'h50,       32'h0,        1,1,0,32'h12345678));
        tv.push_back(mk("alu_op",    1,1,0,RS_ALU,3'b011,32'h13,   32'h0,        1,1,0,32'h0));
        tv.push_back(mk("pc4_op",    1,1,0,RS_PC, W, 32'h41,       32'h0,        1,1,0,32'h0));
        tv.push_back(mk("st_and_ld", 1,0,1,RS_LD, W, 32'h70,       32'h0BADF00D, 1,0,0,32'h0));
        tv.push_back(mk("lw70",      1,1,0,RS_LD, W, 32'h70,       32'h0,        1,1,0,32'h0BADF00D));
        tv.push_back(mk("sw_wrap",   1,0,1,RS_ALU,W, 32'h1080,     32'hA5A5A5A5, 1,0,0,32'h0));
        tv.push_back(mk("lw80",      1,1,0,RS_LD, W, 32'h80,       32'h0,        1,1,0,32'hA5A5A5A5));
        tv.push_back(mk("lhu_wrap",  1,1,0,RS_LD, HU,32'hFFFFF082, 32'h0,        1,1,0,32'h0000A5A5));

        // Reset with a live load presented: outputs must stay zero.
        rst = 1'b1;
        drive(1, 1, 0, RS_LD, W, 5'd7, 32'h10, 32'h0, 32'h44);
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;

        exp_ld = 0; exp_st = 0; exp_tr = 0;
        for (int i = 0; i < tv.size(); i++) begin
            logic [4:0]  rd;
            logic [31:0] pc4;
            t   = tv[i];
            rd  = 5'(i + 1);
            pc4 = 32'h1000 + 32'(4 * i);
            drive(t.v, t.rw, t.mw, t.rs, t.f3, rd, t.addr, t.wd, pc4);
            step();
            chk({t.nm, ".ValidW"},    {31'b0, bus.ValidW},    {31'b0, t.ev});
            chk({t.nm, ".RegWriteW"}, {31'b0, bus.RegWriteW}, {31'b0, t.erw});
            chk({t.nm, ".MisalignW"}, {31'b0, bus.MisalignW}, {31'b0, t.emis});
            if (t.v) begin
                chk({t.nm, ".ReadDataW"},  bus.ReadDataW,           t.erd);
                chk({t.nm, ".RD_W"},       {27'b0, bus.RD_W},       {27'b0, rd});
                chk({t.nm, ".ALUResultW"}, bus.ALUResultW,          t.addr);
                chk({t.nm, ".PCPlus4W"},   bus.PCPlus4W,            pc4);
                chk({t.nm, ".ResultSrcW"}, {30'b0, bus.ResultSrcW}, {30'b0, t.rs});
            end
            if (t.emis) exp_tr++;
            else if (t.v && t.mw) exp_st++;
            else if (t.v && t.rs == RS_LD) exp_ld++;
        end
`ifdef MEM_STATS_EN
        chk("LoadCount",  bus.LoadCount,  exp_ld);
        chk("StoreCount", bus.StoreCount, exp_st);
        chk("TrapCount",  bus.TrapCount,  exp_tr);
`endif

        // Reset mid-stream drops the store presented at the same edge.
        drive(1, 0, 1, RS_ALU, W, 5'd3, 32'h60, 32'h600DD00D, 32'h2000);
        step();
        chk("sw60.MisalignW", {31'b0, bus.MisalignW}, 32'h0);
        rst = 1'b1;
        drive(1, 1, 1, RS_PC, W, 5'd9, 32'h60, 32'hBAD0BAD0, 32'h2004);
        step();
        chk_all_zero("midrst");
        rst = 1'b0;
        drive(1, 1, 0, RS_LD, W, 5'd4, 32'h60, 32'h0, 32'h2008);
        step();
        chk("lw60.ReadDataW", bus.ReadDataW, 32'h600DD00D);
        chk("lw60.RegWriteW", {31'b0, bus.RegWriteW}, 32'h1);
`ifdef MEM_STATS_EN
        chk("lw60.LoadCount",  bus.LoadCount,  32'h1);
        chk("lw60.StoreCount", bus.StoreCount, 32'h0);
`endif

        // Idle cycle with a bubble: control outputs must drop back to zero.
        drive(0, 1, 1, RS_LD, W, 5'd5, 32'h60, 32'h11111111, 32'h200C);
        step();
        chk("idle.ValidW",    {31'b0, bus.ValidW},    32'h0);
        chk("idle.RegWriteW", {31'b0, bus.RegWriteW}, 32'h0);
        drive(1, 1, 0, RS_LD, W, 5'd6, 32'h60, 32'h0, 32'h2010);
        step();
        chk("lw60b.ReadDataW", bus.ReadDataW, 32'h600DD00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
